keypad_debounce_encoder: RTL and testbench
==========================================

# keypad_debounce_encoder

Parametrised keypad front end for the microwave control path. It replaces the fixed 10-key one-hot encoder with four additions:
- an input synchronizer;
- a true debounce FSM for both press and release;
- a selectable multi-key policy;
- one-cycle key event pulses with optional auto-repeat.

It sits between the raw keypad lines and the time-entry/command logic, which consume `key_valid` and `code`.

## Interface
Parameters:
- `N_KEYS`, 10: number of key lines, ≥2; localparam `CODE_W = $clog2(N_KEYS)`.
- `DEBOUNCE_CYCLES`, 4: consecutive matching samples required beyond the first, ≥1; used for press and release.
- `REPEAT_CYCLES`, 0: auto-repeat period in cycles while held; 0 disables repeat.
- `MULTI_MODE`, 0: 0 = reject (multi-key press is treated as no key); 1 = priority (highest bit index wins).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: async active-high reset; clears all state.
- `enable` in 1: synchronous enable; low forces the cleared state.
- `keys` in `N_KEYS`: raw, asynchronous key lines, one bit per key.
- `code` out `CODE_W`: latched key code; bit i maps to code `N_KEYS-1-i` (bit 9 → 0, bit 0 → 9).
- `key_valid` out 1: one-cycle pulse per accepted press or repeat.
- `key_held` out 1: high while a key is accepted and not yet released.
- `multi_err` out 1: registered; high when the synchronized keys have ≥2 bits set.

## Operation
- **Synchronizer:** `keys` passes through a 2-flop synchronizer to give `ks`. All logic below uses `ks` only.
- **Candidate (combinational from `ks`):**
  - One bit set: that bit's code.
  - Zero bits set: none.
  - ≥2 bits set: none in mode 0; highest set index in mode 1.
- **States:** IDLE, DEBOUNCE, PRESSED, RELEASE. Debounce counter `dcnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits; repeat counter `rcnt` is `$clog2(REPEAT_CYCLES+1)` bits.
- **IDLE:** a candidate is present → DEBOUNCE, latch candidate as `pend`, `dcnt`=1.
- **DEBOUNCE:**
  - Candidate == `pend` and `dcnt`==`DEBOUNCE_CYCLES` → PRESSED, `code`←`pend`, `key_valid`=1, `rcnt`=0.
  - Candidate == `pend`, count not reached → `dcnt`++.
  - Candidate is a different key → restart with the new `pend`, `dcnt`=1.
  - No candidate → IDLE.
- **PRESSED:**
  - `key_held`=1.
  - `ks`==0 → RELEASE, `dcnt`=1.
  - Any other nonzero `ks`, including a different key or multi-key, is ignored (no rollover).
  - If `REPEAT_CYCLES`>0: `rcnt` increments each PRESSED cycle; on reaching `REPEAT_CYCLES`, pulse `key_valid`, `rcnt`=0, `code` unchanged.
- **RELEASE:**
  - `key_held`=1, `rcnt` frozen.
  - `ks`==0 and `dcnt`==`DEBOUNCE_CYCLES` → IDLE; `key_held` falls.
  - `ks`==0, count not reached → `dcnt`++.
  - `ks`≠0 → back to PRESSED with no new pulse, and `rcnt` resumes.
- **`code`:** holds its last accepted value after release, until the next accepted press.
- **`enable` low (synchronous):** state←IDLE; counters, sync flops, `code`, `key_valid`, `key_held` and `multi_err` ← 0. This takes precedence over all transitions.
- **`reset` high (asynchronous):** same cleared values, applied immediately. Reset mid-DEBOUNCE or mid-PRESSED emits no pulse. After deassertion, a full debounce is required.

## Timing
- Reset values: `code`=0, `key_valid`=0, `key_held`=0, `multi_err`=0, state IDLE.
- Press latency:
  - Let E0 be the first edge that samples the new `keys` into sync stage 1.
  - `ks` is valid after E1.
  - DEBOUNCE is entered at E2.
  - `key_valid` is high for exactly the one cycle following E(`DEBOUNCE_CYCLES`+2). With defaults, that is after E6.
- `code` updates on the same edge as the first `key_valid` and is stable while `key_valid` is high.
- Repeat: first pulse at cycle t; repeats at t+R, t+2R, … for each cycle spent in PRESSED. RELEASE cycles do not count.
- Release: `key_held` falls `DEBOUNCE_CYCLES`+1 edges after `ks` first reads 0, provided no bounce.
- `multi_err` lags `ks` by one cycle.
- A press and a release can never produce `key_valid` on the same cycle.

## Structure
- Package `keypad_pkg`:
  - state enum `kp_state_t` (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - mode constants `KP_MULTI_REJECT`=0 and `KP_MULTI_PRIORITY`=1;
  - a function giving the candidate code and a found flag from a vector.
- Sub-module `sync_2ff`: width-parametrised 2-flop synchronizer with async reset. Instantiated once, `N_KEYS` wide.

## Test plan
Defaults (`N_KEYS`=10, `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=0, mode 0) apply unless a scenario says otherwise.
1. Clean press: `keys`=10'b0000000100 held 20 cycles → single `key_valid` after E6 with `code`=7. `key_held` stays 1 until 5 edges after `ks`=0, then falls; `code` stays 7.
2. Press bounce: `keys` toggles 0/10'b0000000001 every 2 cycles for 12 cycles, then stays 0 → no `key_valid`, `key_held`=0 throughout.
3. Multi-key: `keys`=10'b1100000000 → in mode 0, no `key_valid` and `multi_err`=1. In mode 1, `key_valid` with `code`=0.
4. Auto-repeat with `REPEAT_CYCLES`=20: key 10'b0100000000 held 70 cycles past the first pulse → pulses at t, t+20, t+40, t+60, all with `code`=1.
5. Release bounce: while PRESSED, `keys`=0 for 2 cycles then back to the same key → no new pulse, `key_held` stays 1. A later clean release returns to IDLE.
6. Reset and enable: `reset` asserted, and separately `enable` dropped, at DEBOUNCE `dcnt`=3 → all outputs 0 and no pulse. After re-enable, the full E6 latency applies again.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debounce/encoder front end.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int KP_MULTI_REJECT   = 0;
  localparam int KP_MULTI_PRIORITY = 1;

  // Widest key vector the helpers accept; narrower vectors are zero-extended.
  localparam int KP_MAX_KEYS = 64;

  // Candidate key from a synchronized vector: returns the found flag, code via 'code'.
  // Key bit i maps to code n_keys-1-i; the ascending scan leaves the highest index.
  function automatic logic kp_candidate(
    input  logic [KP_MAX_KEYS-1:0] vec,
    input  int                     n_keys,
    input  int                     mode,
    output int                     code
  );
    int   cnt;
    int   hi_code;
    logic hit;
    logic found;
    cnt     = 0;
    hi_code = 0;
    for (int i = 0; i < KP_MAX_KEYS; i++) begin
      hit = (i < n_keys) && vec[i];
      if (hit) begin
        cnt     = cnt + 1;
        hi_code = n_keys - 1 - i;
      end else begin
        cnt     = cnt;
      end
    end
    if (cnt == 1) begin
      found = 1'b1;
    end else if ((cnt >= 2) && (mode == KP_MULTI_PRIORITY)) begin
      found = 1'b1;
    end else begin
      found = 1'b0;
    end
    code = found ? hi_code : 0;
    return found;
  endfunction

  // True when two or more keys are set.
  function automatic logic kp_multi(input logic [KP_MAX_KEYS-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < KP_MAX_KEYS; i++) begin
      cnt = cnt + (vec[i] ? 1 : 0);
    end
    return (cnt >= 2);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parametrised two-flop synchronizer with async reset and a synchronous clear.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two-stage capture of the asynchronous lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= {WIDTH{1'b0}};
      q      <= {WIDTH{1'b0}};
    end else if (clr) begin
      meta_r <= {WIDTH{1'b0}};
      q      <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: synchronizes raw key lines, debounces press and release,
// applies the multi-key policy and emits key event pulses with optional auto-repeat.
module keypad_debounce_encoder
  import keypad_pkg::*;
#(
  parameter int  N_KEYS          = 10,
  parameter int  DEBOUNCE_CYCLES = 4,
  parameter int  REPEAT_CYCLES   = 0,
  parameter int  MULTI_MODE      = KP_MULTI_REJECT,
  localparam int CODE_W          = $clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_KEYS-1:0] keys,
  output logic [CODE_W-1:0] code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_err
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCNT_W = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);
  localparam logic [RCNT_W-1:0] RCNT_ZERO = RCNT_W'(0);
  // Pulse fires on the edge where the count would reach REPEAT_CYCLES.
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

  logic [N_KEYS-1:0] ks_s;
  logic              cand_found_s;
  int                cand_int_s;
  logic [CODE_W-1:0] cand_code_s;
  logic              any_key_s;
  logic              multi_s;

  kp_state_t         state_r;
  logic [CODE_W-1:0] pend_r;
  logic [DCNT_W-1:0] dcnt_r;
  logic [RCNT_W-1:0] rcnt_r;

  sync_2ff #(
    .WIDTH (N_KEYS)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .clr   (!enable),
    .d     (keys),
    .q     (ks_s)
  );

  // Candidate key and multi-key flag decoded from the synchronized lines.
  always_comb begin
    cand_int_s   = 0;
    cand_found_s = kp_candidate(KP_MAX_KEYS'(ks_s), N_KEYS, MULTI_MODE, cand_int_s);
    cand_code_s  = CODE_W'(cand_int_s);
    any_key_s    = |ks_s;
    multi_s      = kp_multi(KP_MAX_KEYS'(ks_s));
  end

  // Debounce / hold / release state machine with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      pend_r    <= {CODE_W{1'b0}};
      dcnt_r    <= {DCNT_W{1'b0}};
      rcnt_r    <= {RCNT_W{1'b0}};
      code      <= {CODE_W{1'b0}};
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else if (!enable) begin
      state_r   <= IDLE;
      pend_r    <= {CODE_W{1'b0}};
      dcnt_r    <= {DCNT_W{1'b0}};
      rcnt_r    <= {RCNT_W{1'b0}};
      code      <= {CODE_W{1'b0}};
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= multi_s;
      case (state_r)
        IDLE: begin
          if (cand_found_s) begin
            state_r <= DEBOUNCE;
            pend_r  <= cand_code_s;
            dcnt_r  <= DCNT_ONE;
          end else begin
            state_r <= IDLE;
          end
        end
        DEBOUNCE: begin
          if (!cand_found_s) begin
            state_r <= IDLE;
          end else if (cand_code_s != pend_r) begin
            pend_r <= cand_code_s;
            dcnt_r <= DCNT_ONE;
          end else if (dcnt_r == DCNT_MAX) begin
            state_r   <= PRESSED;
            code      <= pend_r;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            rcnt_r    <= RCNT_ZERO;
          end else begin
            dcnt_r <= dcnt_r + DCNT_ONE;
          end
        end
        PRESSED: begin
          // Nonzero lines, even a different key, keep the current press (no rollover).
          if (!any_key_s) begin
            state_r <= RELEASE;
            dcnt_r  <= DCNT_ONE;
          end else begin
            state_r <= PRESSED;
          end
          if (REPEAT_CYCLES > 0) begin
            if (rcnt_r == RCNT_LAST) begin
              rcnt_r    <= RCNT_ZERO;
              key_valid <= 1'b1;
            end else begin
              rcnt_r <= rcnt_r + RCNT_ONE;
            end
          end else begin
            rcnt_r <= RCNT_ZERO;
          end
        end
        RELEASE: begin
          if (any_key_s) begin
            state_r <= PRESSED;
          end else if (dcnt_r == DCNT_MAX) begin
            state_r  <= IDLE;
            key_held <= 1'b0;
          end else begin
            dcnt_r <= dcnt_r + DCNT_ONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder: three instances (reject, priority, repeat=20)
// checked every cycle against a cycle-count model, plus table vectors and corner sequences.
module tb_keypad_debounce_encoder;

  localparam int N   = 10;
  localparam int DEB = 4;
  localparam int REP = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] keys;

  logic [3:0] code_a, code_b, code_c;
  logic       kv_a, kv_b, kv_c;
  logic       kh_a, kh_b, kh_c;
  logic       me_a, me_b, me_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_debounce_encoder #(.N_KEYS(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(0), .MULTI_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .keys(keys),
    .code(code_a), .key_valid(kv_a), .key_held(kh_a), .multi_err(me_a));
  keypad_debounce_encoder #(.N_KEYS(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(0), .MULTI_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .keys(keys),
    .code(code_b), .key_valid(kv_b), .key_held(kh_b), .multi_err(me_b));
  keypad_debounce_encoder #(.N_KEYS(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .MULTI_MODE(0)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .keys(keys),
    .code(code_c), .key_valid(kv_c), .key_held(kh_c), .multi_err(me_c));

  // Model state: counts of consecutive matching samples rather than named FSM states.
  typedef struct {
    logic [9:0] s1;
    logic [9:0] ks;
    bit         held;
    int         run;
    int         last;
    int         zero;
    int         pcnt;
    int         code;
    bit         valid;
    bit         multi;
  } mdl_t;

  typedef struct {
    logic [9:0] k;
    int         hold;
    int         pulses;
    int         code;
    int         multi;
  } vec_t;

  mdl_t m_a, m_b, m_c;
  vec_t tbl[8];

  function automatic mdl_t mclear();
    mdl_t z;
    z.s1 = '0; z.ks = '0; z.held = 0; z.run = 0; z.last = -1;
    z.zero = 0; z.pcnt = 0; z.code = 0; z.valid = 0; z.multi = 0;
    return z;
  endfunction

  function automatic int cand(logic [9:0] v, bit pri);
    int hi;
    int n;
    hi = -1;
    n  = $countones(v);
    for (int i = 0; i < N; i++) if (v[i]) hi = i;
    if (n == 1 || (n >= 2 && pri)) return N - 1 - hi;
    return -1;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [9:0] k, bit en, int rep, bit pri);
    mdl_t n;
    int   c;
    if (!en) return mclear();
    n       = m;
    n.valid = 0;
    n.multi = ($countones(m.ks) >= 2);
    n.s1    = k;
    n.ks    = m.s1;
    c       = cand(m.ks, pri);
    if (!m.held) begin
      if (c < 0) begin
        n.run = 0;
      end else begin
        n.run  = (m.run > 0 && c == m.last) ? m.run + 1 : 1;
        n.last = c;
        if (n.run == DEB + 1) begin
          n.held = 1; n.code = c; n.valid = 1; n.pcnt = 0; n.run = 0;
        end
      end
    end else begin
      if (m.zero == 0 && rep > 0) begin
        n.pcnt = m.pcnt + 1;
        if (n.pcnt == rep) begin
          n.valid = 1; n.pcnt = 0;
        end
      end
      if (m.ks == 10'b0) begin
        n.zero = m.zero + 1;
        if (n.zero == DEB + 1) begin
          n.held = 0; n.zero = 0;
        end
      end else begin
        n.zero = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a <= mclear();
      m_b <= mclear();
      m_c <= mclear();
    end else begin
      m_a <= mstep(m_a, keys, enable, 0, 1'b0);
      m_b <= mstep(m_b, keys, enable, 0, 1'b1);
      m_c <= mstep(m_c, keys, enable, REP, 1'b0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic [3:0] cd, input logic kv,
                     input logic kh, input logic me);
    chk({tag, "_code"}, cd, m.code);
    chk({tag, "_valid"}, kv, m.valid);
    chk({tag, "_held"}, kh, m.held);
    chk({tag, "_multi"}, me, m.multi);
  endtask

  task automatic tick();
    @(negedge clk);
    cmp("mdl_a", m_a, code_a, kv_a, kh_a, me_a);
    cmp("mdl_b", m_b, code_b, kv_b, kh_b, me_b);
    cmp("mdl_c", m_c, code_c, kv_c, kh_c, me_c);
  endtask

  initial begin
    logic [9:0] pat;
    int np, nb, cd, ms, first, len, lastcode;
    int pulses[$];

    tbl[0] = '{10'b0000000100, 20, 1, 7, 0};
    tbl[1] = '{10'b1100000000, 10, 0, 0, 1};
    tbl[2] = '{10'b0000100000,  4, 0, 0, 0};
    tbl[3] = '{10'b0000100000,  5, 1, 4, 0};
    tbl[4] = '{10'b1000000000,  8, 1, 0, 0};
    tbl[5] = '{10'b0000000001,  8, 1, 9, 0};
    tbl[6] = '{10'b0001000000,  6, 1, 3, 0};
    tbl[7] = '{10'b0000000000,  6, 0, 0, 0};

    reset = 1'b1; enable = 1'b1; keys = '0;
    repeat (3) tick();
    chk("rst_code", code_a, 0);
    chk("rst_valid", kv_a, 0);
    chk("rst_held", kh_a, 0);
    chk("rst_multi", me_a, 0);
    reset = 1'b0;
    tick();

    // Clean press: pulse after E6, held until 5 edges after ks reads 0.
    keys = 10'b0000000100;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c <= 9) chk("t1_latency", kv_a, (c == 7));
      if (c == 7) chk("t1_code", code_a, 7);
      if (c == 20) keys = '0;
      if (c == 26) chk("t1_held_before", kh_a, 1);
      if (c == 27) chk("t1_held_fall", kh_a, 0);
    end
    chk("t1_code_hold", code_a, 7);

    // Press bounce: 2-cycle glitches never qualify.
    np = 0; nb = 0;
    for (int c = 0; c < 30; c++) begin
      keys = (c < 12 && (c % 4) >= 2) ? 10'b0000000001 : 10'b0000000000;
      tick();
      if (kv_a) np++;
      if (kh_a) nb++;
    end
    chk("t2_pulses", np, 0);
    chk("t2_held", nb, 0);

    // Multi-key: reject vs priority instance.
    keys = 10'b1100000000; np = 0; nb = 0; cd = -1; ms = 0;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 14) keys = '0;
      if (kv_a) np++;
      if (kv_b) begin nb++; cd = code_b; end
      if (me_a) ms = 1;
    end
    chk("t3_rej_pulses", np, 0);
    chk("t3_multi_err", ms, 1);
    chk("t3_pri_pulses", nb, 1);
    chk("t3_pri_code", cd, 0);

    // Auto-repeat every 20 PRESSED cycles.
    keys = 10'b0100000000; cd = 0;
    pulses.delete();
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (kv_c) begin
        pulses.push_back(c);
        if (code_c != 4'd1) cd++;
      end
      if (c == 77) keys = '0;
    end
    chk("t4_count", pulses.size(), 4);
    chk("t4_code", cd, 0);
    for (int i = 0; i < pulses.size(); i++) chk("t4_time", pulses[i], 7 + 20 * i);

    // Release bounce returns to PRESSED without a pulse.
    keys = 10'b0000001000; first = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (kh_a && first == 0) first = c;
    end
    chk("t5_pressed", first, 7);
    np = 0; nb = 0;
    keys = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 2) keys = 10'b0000001000;
      if (kv_a) np++;
      if (!kh_a) nb++;
    end
    chk("t5_no_pulse", np, 0);
    chk("t5_held", nb, 0);
    keys = '0;
    repeat (12) tick();
    chk("t5_release", kh_a, 0);
    chk("t5_code", code_a, 6);

    // Reset at dcnt=3, then full latency again.
    keys = 10'b0000010000; np = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (kv_a) np++;
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_code", code_a, 0);
    chk("t6_rst_valid", kv_a, 0);
    chk("t6_rst_held", kh_a, 0);
    chk("t6_rst_multi", me_a, 0);
    chk("t6_rst_nopulse", np, 0);
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("t6_rst_latency", kv_a, (c == 7));
      if (c == 7) chk("t6_rst_code5", code_a, 5);
    end
    keys = '0;
    repeat (12) tick();

    // Enable drop at dcnt=3.
    keys = 10'b0010000000; np = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (kv_a) np++;
    end
    enable = 1'b0;
    tick();
    chk("t6_en_code", code_a, 0);
    chk("t6_en_valid", kv_a, 0);
    chk("t6_en_held", kh_a, 0);
    chk("t6_en_nopulse", np, 0);
    enable = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("t6_en_latency", kv_a, (c == 7));
      if (c == 7) chk("t6_en_code2", code_a, 2);
    end
    keys = '0;
    repeat (12) tick();

    // Table-driven press vectors on the reject instance.
    lastcode = 2;
    for (int v = 0; v < 8; v++) begin
      np = 0; cd = -1; ms = 0;
      keys = tbl[v].k;
      for (int c = 1; c <= tbl[v].hold + 14; c++) begin
        tick();
        if (c == tbl[v].hold) keys = '0;
        if (kv_a) begin np++; cd = code_a; end
        if (me_a) ms = 1;
      end
      chk("tbl_pulses", np, tbl[v].pulses);
      if (tbl[v].pulses > 0) begin
        chk("tbl_code", cd, tbl[v].code);
        lastcode = tbl[v].code;
      end
      chk("tbl_multi", ms, tbl[v].multi);
      chk("tbl_idle", kh_a, 0);
      chk("tbl_code_hold", code_a, lastcode);
    end

    // Randomized segments checked against the model every cycle.
    for (int s = 0; s < 300; s++) begin
      len = $urandom_range(0, 9);
      if (len < 3) pat = 10'b0;
      else if (len < 8) pat = 10'b1 << $urandom_range(0, 9);
      else pat = (10'b1 << $urandom_range(0, 9)) | (10'b1 << $urandom_range(0, 9));
      keys = pat;
      if ($urandom_range(0, 39) == 0) enable = 1'b0;
      if ($urandom_range(0, 59) == 0) reset = 1'b1;
      tick();
      enable = 1'b1;
      reset  = 1'b0;
      len = $urandom_range(1, 14);
      repeat (len) tick();
    end
    keys = '0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
